// File: rtl/pic_pkg.sv
// pic_pkg: register offsets, FSM encoding and ID helpers shared by the
// interrupt controller files.
package pic_pkg;

  localparam int ID_W    = 3;
  localparam int HWINT_W = 6;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_MASK    = 3'd1;
  localparam logic [2:0] OFF_MODE    = 3'd2;
  localparam logic [2:0] OFF_PENDING = 3'd3;
  localparam logic [2:0] OFF_CLAIM   = 3'd4;
  localparam logic [2:0] OFF_EOI     = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } pic_state_e;

  // ID 0 means "none" and maps to an all-zero vector.
  function automatic logic [HWINT_W-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [HWINT_W-1:0] oh;
    oh = '0;
    for (int i = 0; i < HWINT_W; i++) begin
      if (id == ID_W'(i + 1)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/pic_if.sv
// pic_if: CPU bridge register port of the interrupt controller.
// A write transfer happens on every rising clk edge where sel && we; the
// slave is always ready, so there is no back-pressure. rdata is combinational
// from addr and valid in the same cycle.
interface pic_if;
  logic        sel;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output sel, output addr, output wdata, output we, input rdata);
  modport slave  (input sel, input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/pic_prio_enc.sv
// pic_prio_enc: combinational priority encoder, lowest index wins; the
// returned ID is index+1 so that 0 can mean "no request".
module pic_prio_enc
  import pic_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/pic_ctrl.sv
// pic_ctrl: programmable interrupt controller driving CPU HWInt[7:2].
// Define PIC_SYNC_EN to add a 2-flop synchroniser on every irq_in line.
module pic_ctrl
  import pic_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  pic_if.slave             bus,
  output logic [5:0]       hwint,
  output pic_state_e       dbg_state_o
);

  logic               ctrl_en_q;
  logic [N_SRC-1:0]   mask_q, mode_q;
  logic [N_SRC-1:0]   smp, prev_q, rise;
  logic [N_SRC-1:0]   pend_q, pend_d, pend_clr, claim_clr;
  pic_state_e         state_q, state_d;
  logic [ID_W-1:0]    sel_id_q, sel_id_d, in_svc_q, in_svc_d;
  logic [HWINT_W-1:0] hwint_q, hwint_d, sel_oh;
  logic [N_SRC-1:0]   sel_vec;
  logic               cand_valid;
  logic [ID_W-1:0]    cand_id, wr_id;
  logic               wr_en, wr_ctrl, wr_mask, wr_mode, wr_pend, wr_claim, wr_eoi;
  logic [31:0]        rdata_c;
  logic               unused_wdata;

  assign wr_en    = bus.sel & bus.we;
  assign wr_ctrl  = wr_en && (bus.addr == OFF_CTRL);
  assign wr_mask  = wr_en && (bus.addr == OFF_MASK);
  assign wr_mode  = wr_en && (bus.addr == OFF_MODE);
  assign wr_pend  = wr_en && (bus.addr == OFF_PENDING);
  assign wr_claim = wr_en && (bus.addr == OFF_CLAIM);
  assign wr_eoi   = wr_en && (bus.addr == OFF_EOI);
  assign wr_id    = bus.wdata[ID_W-1:0];
  assign unused_wdata = ^bus.wdata[31:N_SRC];

`ifdef PIC_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign smp = sync2_q;
`else
  assign smp = irq_in;
`endif

  assign rise = smp & ~prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en_q <= 1'b0;
      mask_q    <= '0;
      mode_q    <= '0;
    end else begin
      if (wr_ctrl) ctrl_en_q <= bus.wdata[0];
      if (wr_mask) mask_q    <= bus.wdata[N_SRC-1:0];
      if (wr_mode) mode_q    <= bus.wdata[N_SRC-1:0];
    end
  end

  // A new edge beats a same-cycle software or claim clear.
  assign pend_clr = ({N_SRC{wr_pend}} & bus.wdata[N_SRC-1:0]) | claim_clr;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i]) pend_d[i] = rise[i] | (pend_q[i] & ~pend_clr[i]);
      else           pend_d[i] = smp[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= smp;
      pend_q <= pend_d;
    end
  end

  pic_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req   (pend_q & mask_q),
    .valid (cand_valid),
    .id    (cand_id)
  );

  assign sel_oh  = id_to_onehot(sel_id_q);
  assign sel_vec = sel_oh[N_SRC-1:0];

  always_comb begin
    state_d   = state_q;
    sel_id_d  = sel_id_q;
    in_svc_d  = in_svc_q;
    claim_clr = '0;
    case (state_q)
      IDLE: begin
        if (ctrl_en_q && cand_valid) begin
          sel_id_d = cand_id;
          state_d  = ASSERT;
        end
      end
      ASSERT: begin
        // Claim is checked first so it wins over a same-cycle withdraw.
        if (wr_claim && (wr_id == sel_id_q)) begin
          state_d   = SERVICE;
          in_svc_d  = sel_id_q;
          sel_id_d  = '0;
          claim_clr = sel_vec;
        end else if (!ctrl_en_q || !(|(sel_vec & mask_q & pend_q))) begin
          state_d  = IDLE;
          sel_id_d = '0;
        end
      end
      SERVICE: begin
        if (wr_eoi && (wr_id == in_svc_q)) begin
          in_svc_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    hwint_d = (state_d == ASSERT) ? id_to_onehot(sel_id_d) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sel_id_q <= '0;
      in_svc_q <= '0;
      hwint_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_id_q <= sel_id_d;
      in_svc_q <= in_svc_d;
      hwint_q  <= hwint_d;
    end
  end

  assign hwint       = hwint_q;
  assign dbg_state_o = state_q;

  always_comb begin
    rdata_c = '0;
    if (reset) begin
      case (bus.addr)
        OFF_CTRL:    rdata_c[0]         = ctrl_en_q;
        OFF_MASK:    rdata_c[N_SRC-1:0] = mask_q;
        OFF_MODE:    rdata_c[N_SRC-1:0] = mode_q;
        OFF_PENDING: rdata_c[N_SRC-1:0] = pend_q;
        OFF_CLAIM:   if (state_q == ASSERT) rdata_c[ID_W-1:0] = sel_id_q;
        OFF_EOI:     rdata_c[ID_W-1:0]  = in_svc_q;
        default:     rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;

endmodule

// File: doc/pic_ctrl.md
# pic_ctrl

Programmable interrupt controller between the peripheral devices and the CPU's six hardware interrupt lines (HWInt[7:2]). Latches device requests (edge or level per source), applies mask and fixed priority, and drives exactly one interrupt line. Holds that line until the handler claims it, then tracks the in-service source until end-of-interrupt. Its registers sit on the CPU bridge: PrAddr, PrWD, PrWE, PrRD, decoded by the bridge into `sel`.

## Interface
- N_SRC, 6: number of device sources, 1..6; source i maps to hwint[i].
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- irq_in  in  N_SRC  raw device requests, active-high.
- sel  in  1  bridge select for this block.
- addr  in  3  word offset, PrAddr[4:2].
- wdata  in  32  write data, PrWD.
- we  in  1  write strobe; effective only when sel=1.
- rdata  out  32  read data to bridge, combinational from addr; 0 while reset is asserted.
- hwint  out  6  to CPU HWInt[7:2], registered; 0 while reset is asserted.

## Operation
Source IDs: source i has ID i+1; ID 0 means none. IDs are 3 bits wide.

Register map (word offsets):
- 0 CTRL: bit0 = global enable. Reset value 0.
- 1 MASK: bit i = 1 enables source i. Reset value 0.
- 2 MODE: bit i = 1 selects edge mode, 0 selects level mode. Reset value 0.
- 3 PENDING: read returns pending bits. A write of 1 clears an edge-mode bit; writes have no effect on level-mode bits.
- 4 CLAIM: read returns the selected ID while in ASSERT, otherwise 0. A write of the matching ID claims the interrupt.
- 5 EOI: read returns the in-service ID. A write of the matching ID ends service.
- 6, 7: read 0; writes ignored.

Pending rules:
- Edge mode: a bit sets on a rising edge of the (synchronised) input.
- Level mode: the bit equals the sampled level.
- If a set and a write-1-clear hit the same cycle, set wins.

Candidate: lowest-index bit of PENDING & MASK, computed by the priority encoder.

FSM (state reset value IDLE; in_service reset value 0):
- IDLE
  - Leave when CTRL.en=1 and a candidate exists.
  - Latch the candidate ID into `sel_id` and go to ASSERT.
- ASSERT
  - hwint = one-hot of sel_id.
  - CLAIM write with wdata[2:0]==sel_id: go to SERVICE, set in_service=sel_id, clear the edge pending bit.
  - CLAIM write with any other value: ignored.
  - If CTRL.en=0, or the selected source becomes unmasked-off or non-pending: go back to IDLE (spurious withdraw).
  - Claim has priority over withdraw in the same cycle.
- SERVICE
  - hwint = 0.
  - EOI write with wdata[2:0]==in_service: set in_service=0, go to IDLE.
  - No nesting: new requests stay pending.
  - CTRL.en has no effect in this state.

## Timing
- PIC_SYNC_EN defined: pending sets on the 3rd rising edge after irq_in rises.
- PIC_SYNC_EN undefined: pending sets on the 1st rising edge after irq_in rises.
- hwint asserts one edge after pending is visible. Total latency is 4 or 2 edges.
- hwint falls on the edge that samples the claim write (or the withdraw condition), so it is low one cycle later.
- With a new candidate present, IDLE→ASSERT after EOI takes one edge, so hwint reasserts 2 edges after the EOI write.
- Reset mid-operation:
  - All registers, pending bits, synchronisers and the FSM clear immediately.
  - hwint goes to 0 asynchronously.

## Configuration
- PIC_SYNC_EN defined: each irq_in passes through a 2-flop synchroniser before edge detection and level sampling.
- PIC_SYNC_EN undefined: irq_in is sampled directly by a single flop used for edge detection; irq_in must be synchronous to clk.
- The register map and FSM are identical in both cases.

## Structure
- Package `pic_pkg`:
  - register offsets (CTRL..EOI)
  - FSM state encoding (IDLE, ASSERT, SERVICE)
  - ID width (3)
- Sub-module `pic_prio_enc`:
  - combinational lowest-index-first encoder
  - input: N_SRC-bit vector
  - outputs: `valid` and a 3-bit ID

## Test plan
- Edge interrupt: MASK=1, MODE=1, CTRL=1, pulse irq_in[0] for one cycle. Expect hwint=6'b000001 after 4 edges (PIC_SYNC_EN). Write CLAIM=1 → hwint=0, EOI reads 1, PENDING=0. Write EOI=1 → EOI reads 0.
- Priority: irq_in[2] and irq_in[4] rise together, both masked on, level mode. Expect CLAIM read 3 and hwint=6'b000100. After EOI=3 with irq_in[2] deasserted, expect hwint=6'b010000 two edges later.
- Wrong claim: in ASSERT with sel_id=2, write CLAIM=5. Expect state unchanged and hwint held. Write CLAIM=2 → SERVICE.
- Spurious withdraw: level source 1 asserted and hwint=6'b000010, then clear MASK bit 1. Expect hwint=0 next cycle and CLAIM read 0.
- Simultaneous set/clear: edge source 3 already pending; write PENDING=0x8 in the same cycle as a new rising edge arrives. Expect the PENDING bit to remain 1.
- Reset mid-SERVICE: assert reset low while in_service=4. Expect hwint=0, rdata=0 and all registers 0 immediately. After release, no interrupt until CTRL and MASK are reprogrammed.
